// File: rtl/ram_fifo_if.sv
// ram_fifo_if: producer/consumer valid-ready stream bundle for ram_fifo_ctrl.
interface ram_fifo_if #(parameter int DATA_WIDTH = 16);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: block-RAM FIFO controller with a 2-entry output buffer hiding the read latency.
// Optional watermark flags are built when RAM_FIFO_WATERMARK_EN is defined.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_fifo_if.slave             s,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]   r_ram_count, r_count;
    logic                  r_in_ready, r_inflight;
    logic [1:0]            r_buf_count;
    logic [DATA_WIDTH-1:0] r_head, r_skid;
    logic                  w_push, w_pop, w_re;
    logic [1:0]            w_b1;
    logic [ADDR_WIDTH:0]   w_ram_cnt_nxt, w_count_nxt;
    assign w_push        = s.in_valid && r_in_ready;
    assign w_pop         = (r_buf_count != 2'd0) && s.out_ready;
    assign w_re          = (r_ram_count != '0) &&
                           (({1'b0, r_buf_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
    assign w_b1          = r_buf_count - {1'b0, w_pop};
    assign w_ram_cnt_nxt = r_ram_count + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_re);
    assign w_count_nxt   = r_count + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);
    assign s.in_ready    = r_in_ready;
    assign s.out_valid   = r_buf_count != 2'd0;
    assign s.out_data    = r_head;
    assign count         = r_count;
    assign ram_we        = w_push;
    assign ram_waddr     = r_wptr;
    assign ram_d         = s.in_data;
    assign ram_re        = w_re;
    assign ram_raddr     = r_rptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ram_count <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_inflight  <= 1'b0;
            r_buf_count <= 2'd0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            r_wptr      <= r_wptr + ADDR_WIDTH'(w_push);
            r_rptr      <= r_rptr + ADDR_WIDTH'(w_re);
            r_ram_count <= w_ram_cnt_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= w_ram_cnt_nxt < L_DEPTH;
            r_inflight  <= w_re;
            // landed word fills the head if the pop left it empty, else the skid slot
            r_head      <= (r_inflight && w_b1 == 2'd0) ? ram_q : (w_pop ? r_skid : r_head);
            if (r_inflight && w_b1 == 2'd1)
                r_skid <= ram_q;
            r_buf_count <= w_b1 + {1'b0, r_inflight};
        end
    end
`ifdef RAM_FIFO_WATERMARK_EN
    logic r_af, r_ae;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_af <= 1'b0;
            r_ae <= 1'b1;
        end else begin
            r_af <= w_count_nxt >= (ADDR_WIDTH+1)'(AF_LEVEL);
            r_ae <= w_count_nxt <= (ADDR_WIDTH+1)'(AE_LEVEL);
        end
    end
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif
endmodule
